// File: rtl/twos_addsub_serial.sv
// Digit-serial two's-complement adder/subtractor with optional signed saturation.
// Latency: NDIG = WIDTH/DIGIT cycles from accepted start to the done pulse.
// Backpressure: none; start is ignored while busy, results are held until the next done.
//
// Ports:
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   start, sub, x, y       request; operands and mode are captured only when start is accepted
//   busy, done             busy while digits are being processed; done pulses one cycle per result
//   s, carry, overflow     registered result, unsigned carry-out (1 = no borrow), signed overflow
module twos_addsub_serial #(
   parameter int WIDTH  = 16,
   parameter int DIGIT  = 4,
   parameter int SAT_EN = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             carry,
   output logic             overflow
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

   generate
      if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
         $error("twos_addsub_serial: WIDTH must be >= 2 and a multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;        // already inverted for subtract
   logic [WIDTH-1:0] r_sum;      // partial sum, filled one digit per RUN cycle
   logic             r_c;        // running carry between digits
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_s;
   logic             r_carry;
   logic             r_ovf;

   logic             w_accept;
   logic             w_last;
   logic [31:0]      w_base;
   logic [DIGIT:0]   w_dsum;
   logic [WIDTH-1:0] w_full;
   logic             w_ovf;
   logic [WIDTH-1:0] w_res;

   // DONE accepts a new start too, so back-to-back operations have no gap.
   assign w_accept = start && (r_state != S_RUN);
   assign w_last   = (r_cnt == LAST_DIG);
   assign w_base   = 32'(r_cnt) * DIGIT;

   assign w_dsum = {1'b0, r_a[w_base +: DIGIT]} + {1'b0, r_b[w_base +: DIGIT]}
                 + {{DIGIT{1'b0}}, r_c};

   // Partial sum with the current digit merged in; on the last digit this is the full result.
   always_comb begin
      w_full = r_sum;
      w_full[w_base +: DIGIT] = w_dsum[DIGIT-1:0];
   end

   assign w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_full[WIDTH-1] != r_a[WIDTH-1]);

   // Overflow direction follows operand A: positive A can only overflow upwards.
   always_comb begin
      w_res = w_full;
      if ((SAT_EN != 0) && w_ovf) begin
         w_res = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = w_accept ? S_RUN : S_IDLE;
         S_RUN:   w_next = w_last ? S_DONE : S_RUN;
         S_DONE:  w_next = w_accept ? S_RUN : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_c     <= 1'b0;
         r_cnt   <= '0;
         r_s     <= '0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         r_a   <= x;
         r_b   <= sub ? ~y : y;
         r_c   <= sub;               // +1 completes the two's-complement negation of y
         r_sum <= '0;
         r_cnt <= '0;
      end else if (r_state == S_RUN) begin
         r_sum <= w_full;
         r_c   <= w_dsum[DIGIT];
         r_cnt <= r_cnt + CW'(1);
         if (w_last) begin
            r_s     <= w_res;
            r_carry <= w_dsum[DIGIT];
            r_ovf   <= w_ovf;
         end
      end
   end

   assign busy     = (r_state == S_RUN);
   assign done     = (r_state == S_DONE);
   assign s        = r_s;
   assign carry    = r_carry;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_twos_addsub_serial.sv
// Testbench for twos_addsub_serial: four instances (DIGIT 4 raw / 4 saturating / 1 / 16).
// Latency: checks NDIG-cycle done timing per instance.
// Backpressure: exercises ignored mid-run start and back-to-back start in the done cycle.
module tb_twos_addsub_serial;

   typedef struct packed {
      logic [15:0] s;
      logic        c;
      logic        o;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sub = 1'b0;
   logic [15:0] x = '0;
   logic [15:0] y = '0;
   logic [3:0]  start_v = '0;
   logic [3:0]  busy_v;
   logic [3:0]  done_v;
   logic [3:0]  carry_v;
   logic [3:0]  ovf_v;
   logic [15:0] s_v [4];

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   twos_addsub_serial #(.WIDTH(16), .DIGIT(4), .SAT_EN(0)) u_d4 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub), .x(x), .y(y),
      .busy(busy_v[0]), .done(done_v[0]), .s(s_v[0]), .carry(carry_v[0]), .overflow(ovf_v[0]));
   twos_addsub_serial #(.WIDTH(16), .DIGIT(4), .SAT_EN(1)) u_d4_sat (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub), .x(x), .y(y),
      .busy(busy_v[1]), .done(done_v[1]), .s(s_v[1]), .carry(carry_v[1]), .overflow(ovf_v[1]));
   twos_addsub_serial #(.WIDTH(16), .DIGIT(1), .SAT_EN(0)) u_d1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub), .x(x), .y(y),
      .busy(busy_v[2]), .done(done_v[2]), .s(s_v[2]), .carry(carry_v[2]), .overflow(ovf_v[2]));
   twos_addsub_serial #(.WIDTH(16), .DIGIT(16), .SAT_EN(0)) u_d16 (
      .clk(clk), .rst_n(rst_n), .start(start_v[3]), .sub(sub), .x(x), .y(y),
      .busy(busy_v[3]), .done(done_v[3]), .s(s_v[3]), .carry(carry_v[3]), .overflow(ovf_v[3]));

   // Reference arithmetic straight from the two's-complement definition.
   function automatic exp_t model(logic [15:0] a, logic [15:0] b, logic sb, bit sat);
      exp_t        r;
      logic [15:0] bb;
      logic [16:0] t;
      bb  = sb ? ~b : b;
      t   = {1'b0, a} + {1'b0, bb} + 17'(sb);
      r.o = (a[15] == bb[15]) && (t[15] != a[15]);
      r.c = t[16];
      r.s = (sat && r.o) ? (a[15] ? 16'h8000 : 16'h7FFF) : t[15:0];
      return r;
   endfunction

   // Start pulse spanning exactly one rising edge; returns at the negedge after acceptance.
   task automatic do_start(input logic [3:0] mask, input logic [15:0] sx, input logic [15:0] sy,
                           input logic ssub);
      @(negedge clk);
      x = sx; y = sy; sub = ssub; start_v = mask;
      @(negedge clk);
      start_v = '0;
   endtask

   // Counts negedges until done on instance k (bounded); nb = negedges seen with busy high.
   task automatic wait_done(input int k, output int lat, output int nb);
      lat = 0; nb = 0;
      while (done_v[k] !== 1'b1 && lat < 200) begin
         if (busy_v[k] === 1'b1) nb++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if ({busy_v[k], done_v[k], s_v[k], carry_v[k], ovf_v[k]} !== 20'h0) begin
            n_err++;
            $display("FAIL reset_state inst%0d got busy=%b done=%b s=%h c=%b o=%b expected all 0",
                     k, busy_v[k], done_v[k], s_v[k], carry_v[k], ovf_v[k]);
         end
      end
   endtask

   task automatic test_add();
      int lat, nb;
      exp_t e;
      q.push_back({16'h7554, 1'b0, 1'b0});
      do_start(4'b0001, 16'h5555, 16'h1FFF, 1'b0);
      wait_done(0, lat, nb);
      n_cmp++;
      if (lat !== 4) begin n_err++; $display("FAIL add_latency got %0d expected 4", lat); end
      n_cmp++;
      if (nb !== 4) begin n_err++; $display("FAIL add_busy_cycles got %0d expected 4", nb); end
      e = q.pop_front();
      n_cmp++;
      if ({s_v[0], carry_v[0], ovf_v[0]} !== e) begin
         n_err++;
         $display("FAIL add_result got s=%h c=%b o=%b expected s=%h c=%b o=%b",
                  s_v[0], carry_v[0], ovf_v[0], e.s, e.c, e.o);
      end
   endtask

   // Runs one operation on raw (inst0) and saturating (inst1) units together.
   task automatic test_pair(input string nm, input logic [15:0] a, input logic [15:0] b,
                            input logic sb, input exp_t e_raw, input exp_t e_sat);
      int lat, nb;
      exp_t e;
      q.push_back(e_raw);
      q.push_back(e_sat);
      do_start(4'b0011, a, b, sb);
      wait_done(0, lat, nb);
      e = q.pop_front();
      n_cmp++;
      if ({s_v[0], carry_v[0], ovf_v[0]} !== e) begin
         n_err++;
         $display("FAIL %s_raw got s=%h c=%b o=%b expected s=%h c=%b o=%b",
                  nm, s_v[0], carry_v[0], ovf_v[0], e.s, e.c, e.o);
      end
      e = q.pop_front();
      n_cmp++;
      if ({done_v[1], s_v[1], carry_v[1], ovf_v[1]} !== {1'b1, e}) begin
         n_err++;
         $display("FAIL %s_sat got done=%b s=%h c=%b o=%b expected done=1 s=%h c=%b o=%b",
                  nm, done_v[1], s_v[1], carry_v[1], ovf_v[1], e.s, e.c, e.o);
      end
   endtask

   task automatic test_overflow_sub();
      test_pair("ovf_add", 16'h7FFF, 16'h0001, 1'b0, {16'h8000, 1'b0, 1'b1}, {16'h7FFF, 1'b0, 1'b1});
      test_pair("sub_borrow", 16'h0000, 16'h0001, 1'b1, {16'hFFFF, 1'b0, 1'b0}, {16'hFFFF, 1'b0, 1'b0});
      test_pair("sub_ovf", 16'h8000, 16'h0001, 1'b1, {16'h7FFF, 1'b1, 1'b1}, {16'h8000, 1'b1, 1'b1});
   endtask

   task automatic test_wrap();
      int inst[3] = '{0, 2, 3};
      int elat[3] = '{4, 16, 1};
      int lat, nb;
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         q.push_back({16'h0000, 1'b1, 1'b0});
         do_start(4'(1 << inst[i]), 16'hFFFF, 16'h0001, 1'b0);
         wait_done(inst[i], lat, nb);
         n_cmp++;
         if (lat !== elat[i]) begin
            n_err++; $display("FAIL wrap_latency inst%0d got %0d expected %0d", inst[i], lat, elat[i]);
         end
         e = q.pop_front();
         n_cmp++;
         if ({s_v[inst[i]], carry_v[inst[i]], ovf_v[inst[i]]} !== e) begin
            n_err++;
            $display("FAIL wrap_result inst%0d got s=%h c=%b o=%b expected s=%h c=%b o=%b", inst[i],
                     s_v[inst[i]], carry_v[inst[i]], ovf_v[inst[i]], e.s, e.c, e.o);
         end
      end
   endtask

   task automatic test_ignore_start();
      int lat, nb, extra;
      exp_t e;
      q.push_back({16'h3333, 1'b0, 1'b0});
      do_start(4'b0001, 16'h1111, 16'h2222, 1'b0);
      @(negedge clk);
      x = 16'h1234; y = 16'hFFFF; sub = 1'b1; start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      wait_done(0, lat, nb);
      n_cmp++;
      if (lat !== 2) begin n_err++; $display("FAIL ignore_latency got %0d expected 2", lat); end
      e = q.pop_front();
      n_cmp++;
      if ({s_v[0], carry_v[0], ovf_v[0]} !== e) begin
         n_err++;
         $display("FAIL ignore_result got s=%h c=%b o=%b expected s=%h", s_v[0], carry_v[0], ovf_v[0], e.s);
      end
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) extra++;
      end
      n_cmp++;
      if (extra !== 0) begin n_err++; $display("FAIL ignore_no_second_op got %0d active cycles expected 0", extra); end
      n_cmp++;
      if (s_v[0] !== 16'h3333) begin n_err++; $display("FAIL hold_result got s=%h expected 3333", s_v[0]); end
   endtask

   task automatic test_back_to_back();
      int lat, nb;
      exp_t e;
      q.push_back({16'h0300, 1'b0, 1'b0});
      do_start(4'b0001, 16'h0100, 16'h0200, 1'b0);
      wait_done(0, lat, nb);
      e = q.pop_front();
      n_cmp++;
      if ({s_v[0], carry_v[0], ovf_v[0]} !== e) begin
         n_err++; $display("FAIL b2b_first got s=%h expected %h", s_v[0], e.s);
      end
      // Still in the done cycle: request the next operation immediately.
      q.push_back({16'h0002, 1'b0, 1'b0});
      x = 16'h0001; y = 16'h0001; sub = 1'b0; start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      n_cmp++;
      if (busy_v[0] !== 1'b1) begin n_err++; $display("FAIL b2b_busy got %b expected 1", busy_v[0]); end
      wait_done(0, lat, nb);
      n_cmp++;
      if (lat !== 4) begin n_err++; $display("FAIL b2b_latency got %0d expected 4", lat); end
      e = q.pop_front();
      n_cmp++;
      if ({s_v[0], carry_v[0], ovf_v[0]} !== e) begin
         n_err++; $display("FAIL b2b_second got s=%h c=%b o=%b expected s=%h", s_v[0], carry_v[0], ovf_v[0], e.s);
      end
   endtask

   task automatic test_reset_mid();
      int lat, nb, pulses;
      exp_t e;
      do_start(4'b0001, 16'h0F0F, 16'h0101, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy_v[0], done_v[0], s_v[0], carry_v[0], ovf_v[0]} !== 20'h0) begin
         n_err++;
         $display("FAIL reset_mid got busy=%b done=%b s=%h c=%b o=%b expected all 0",
                  busy_v[0], done_v[0], s_v[0], carry_v[0], ovf_v[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done_v !== 4'b0000) pulses++;
      end
      n_cmp++;
      if (pulses !== 0) begin n_err++; $display("FAIL reset_no_done got %0d pulses expected 0", pulses); end
      q.push_back({16'h1000, 1'b0, 1'b0});
      do_start(4'b0001, 16'h0FFF, 16'h0001, 1'b0);
      wait_done(0, lat, nb);
      e = q.pop_front();
      n_cmp++;
      if ({s_v[0], carry_v[0], ovf_v[0]} !== e || lat !== 4) begin
         n_err++;
         $display("FAIL reset_fresh_op got s=%h lat=%0d expected s=%h lat=4", s_v[0], lat, e.s);
      end
   endtask

   task automatic test_random();
      int lat, nb;
      exp_t e;
      logic [15:0] a, b;
      logic sb;
      for (int i = 0; i < 16; i++) begin
         a  = 16'($urandom);
         b  = 16'($urandom);
         sb = 1'($urandom_range(0, 1));
         if (i == 0) begin a = 16'h8000; b = 16'h8000; sb = 1'b0; end
         q.push_back(model(a, b, sb, 1'b0));
         q.push_back(model(a, b, sb, 1'b1));
         do_start(4'b0011, a, b, sb);
         wait_done(0, lat, nb);
         e = q.pop_front();
         n_cmp++;
         if ({s_v[0], carry_v[0], ovf_v[0]} !== e) begin
            n_err++;
            $display("FAIL rand_raw a=%h b=%h sub=%b got s=%h c=%b o=%b expected s=%h c=%b o=%b",
                     a, b, sb, s_v[0], carry_v[0], ovf_v[0], e.s, e.c, e.o);
         end
         e = q.pop_front();
         n_cmp++;
         if ({s_v[1], carry_v[1], ovf_v[1]} !== e) begin
            n_err++;
            $display("FAIL rand_sat a=%h b=%h sub=%b got s=%h c=%b o=%b expected s=%h c=%b o=%b",
                     a, b, sb, s_v[1], carry_v[1], ovf_v[1], e.s, e.c, e.o);
         end
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_add();
      test_overflow_sub();
      test_wrap();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      test_random();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
